// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-cycle RV32I core.
// Walks each instruction through FETCH, DECODE, EXEC, MEM and WB, steering the
// single shared ALU, PC/IR/OldPC registers, register file and unified memory
// port, and counts retired instructions.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (unknown opcodes lock the FSM in
// TRAP with illegal=1 instead of retiring as a NOP).
module multicycle_ctrl #(
  parameter logic [2:0]  RESET_STATE = 3'd0,
  parameter int unsigned INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 ir_we,
  output logic                 oldpc_we,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic [1:0]           alu_a_sel,
  output logic [1:0]           alu_b_sel,
  output logic                 alu_force_add,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LTYPE = 7'b0000011;
  localparam logic [6:0] OP_STYPE = 7'b0100011;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] A_PC      = 2'd0;
  localparam logic [1:0] A_OLDPC   = 2'd1;
  localparam logic [1:0] A_RS1     = 2'd2;
  localparam logic [1:0] B_FOUR    = 2'd0;
  localparam logic [1:0] B_IMM     = 2'd1;
  localparam logic [1:0] B_RS2     = 2'd2;
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_IMM    = 2'd2;

  state_e                 state_q, state_d;
  logic                   jalr_phase_q, jalr_phase_d;
  logic                   illegal_q, illegal_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   retire;

  logic is_rtype, is_itype, is_load, is_store, is_branch;
  logic is_jal, is_jalr, is_lui, is_auipc, is_legal;

  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_itype  = (opcode == OP_ITYPE);
  assign is_load   = (opcode == OP_LTYPE);
  assign is_store  = (opcode == OP_STYPE);
  assign is_branch = (opcode == OP_BTYPE);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_legal  = is_rtype | is_itype | is_load | is_store | is_branch |
                     is_jal | is_jalr | is_lui | is_auipc;

  // Next state, JALR phase, illegal flag and retire counting.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
    state_d      = state_q;
    jalr_phase_d = 1'b0;
    illegal_d    = illegal_q;
    retire       = 1'b0;
    case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d   = S_TRAP;
          illegal_d = 1'b1;
`else
          state_d = S_FETCH;
          retire  = 1'b1;
`endif
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (is_jalr && !jalr_phase_q) begin
          jalr_phase_d = 1'b1;  // stay one more EXEC cycle to form OldPC+4
        end else if (is_legal) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_store) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_FETCH;
    endcase
    instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;
  end

  // Datapath controls: decoded from state and opcode, Mealy on mem_ready and branch_taken.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_we         = 1'b0;
    oldpc_we      = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = 1'b0;
    alu_a_sel     = A_PC;
    alu_b_sel     = B_FOUR;
    alu_force_add = 1'b1;
    rf_we         = 1'b0;
    wb_sel        = WB_ALUOUT;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_we    = mem_ready;
          oldpc_we = mem_ready;
          pc_we    = mem_ready;
        end
        S_DECODE: begin
          alu_a_sel = A_OLDPC;
          alu_b_sel = B_IMM;
        end
        S_EXEC: begin
          if (is_rtype) begin
            alu_a_sel     = A_RS1;
            alu_b_sel     = B_RS2;
            alu_force_add = 1'b0;
          end else if (is_itype) begin
            alu_a_sel     = A_RS1;
            alu_b_sel     = B_IMM;
            alu_force_add = 1'b0;
          end else if (is_load || is_store) begin
            alu_a_sel = A_RS1;
            alu_b_sel = B_IMM;
          end else if (is_branch) begin
            pc_we  = branch_taken;
            pc_sel = 1'b1;
          end else if (is_jal) begin
            pc_we     = 1'b1;
            pc_sel    = 1'b1;
            alu_a_sel = A_OLDPC;
            alu_b_sel = B_FOUR;
          end else if (is_jalr) begin
            if (!jalr_phase_q) begin
              alu_a_sel = A_RS1;
              alu_b_sel = B_IMM;
              pc_we     = 1'b1;
            end else begin
              alu_a_sel = A_OLDPC;
              alu_b_sel = B_FOUR;
            end
          end else if (is_auipc) begin
            // Recompute OldPC+imm so ALUOut keeps the AUIPC result into WB.
            alu_a_sel = A_OLDPC;
            alu_b_sel = B_IMM;
          end
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = is_store;
        end
        S_WB: begin
          rf_we  = 1'b1;
          wb_sel = is_load ? WB_MEM : (is_lui ? WB_IMM : WB_ALUOUT);
        end
        default: ;
      endcase
    end
  end

  // State, JALR phase, illegal flag and retired-instruction counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= state_e'(RESET_STATE);
      jalr_phase_q <= 1'b0;
      illegal_q    <= 1'b0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      jalr_phase_q <= jalr_phase_d;
      illegal_q    <= illegal_d;
      instret_q    <= instret_d;
    end
  end

  assign illegal = illegal_q;
  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed bench for multicycle_ctrl. A per-instruction
// planner turns each opcode and its stall pattern into the expected cycle-by-
// cycle control outputs; one compare process checks the DUT every cycle.
// A narrow retired counter makes the wrap-around reachable.
module tb_multicycle_ctrl;

  localparam int IW = 4;

  localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2,
                         ST_MEM = 3'd3, ST_WB = 3'd4, ST_TRAP = 3'd5;

  localparam logic [6:0] OP_ADD = 7'b0110011, OP_ADDI = 7'b0010011,
                         OP_LW = 7'b0000011, OP_SW = 7'b0100011,
                         OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_BAD = 7'b1111111;

  typedef enum {C_R, C_I, C_L, C_S, C_B, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD} cls_e;

  typedef struct packed {
    logic [2:0]    state;
    logic          mem_req, mem_we, mem_addr_sel, ir_we, oldpc_we, pc_we, pc_sel;
    logic [1:0]    alu_a_sel, alu_b_sel;
    logic          alu_force_add, rf_we;
    logic [1:0]    wb_sel;
    logic          illegal;
    logic [IW-1:0] instret;
  } out_t;

  typedef struct {
    logic       rst, mem_ready, bt, chk;
    logic [6:0] op;
    out_t       exp;
  } cycle_t;

  logic clk = 1'b0;
  logic rst, branch_taken, mem_ready;
  logic [6:0] opcode;
  logic mem_req, mem_we, mem_addr_sel, ir_we, oldpc_we, pc_we, pc_sel;
  logic [1:0] alu_a_sel, alu_b_sel, wb_sel;
  logic alu_force_add, rf_we, illegal;
  logic [IW-1:0] instret;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  cycle_t        plan_q[$];
  logic [IW-1:0] m_instret;
  logic          m_illegal;
  out_t          exp_cur, dut_vec;
  logic          chk_en = 1'b0;
  string         cur_tag = "";

  multicycle_ctrl #(.RESET_STATE(3'd0), .INSTRET_W(IW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .oldpc_we(oldpc_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_force_add(alu_force_add), .rf_we(rf_we),
    .wb_sel(wb_sel), .illegal(illegal), .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  always_comb begin
    dut_vec               = '0;
    dut_vec.state         = state;
    dut_vec.mem_req       = mem_req;
    dut_vec.mem_we        = mem_we;
    dut_vec.mem_addr_sel  = mem_addr_sel;
    dut_vec.ir_we         = ir_we;
    dut_vec.oldpc_we      = oldpc_we;
    dut_vec.pc_we         = pc_we;
    dut_vec.pc_sel        = pc_sel;
    dut_vec.alu_a_sel     = alu_a_sel;
    dut_vec.alu_b_sel     = alu_b_sel;
    dut_vec.alu_force_add = alu_force_add;
    dut_vec.rf_we         = rf_we;
    dut_vec.wb_sel        = wb_sel;
    dut_vec.illegal       = illegal;
    dut_vec.instret       = instret;
  end

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Compare process: outputs sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) check(cur_tag, 64'(dut_vec), 64'(exp_cur));
  end

  function automatic cls_e classify(logic [6:0] op);
    case (op)
      OP_ADD:   return C_R;
      OP_ADDI:  return C_I;
      OP_LW:    return C_L;
      OP_SW:    return C_S;
      OP_BEQ:   return C_B;
      OP_JAL:   return C_JAL;
      OP_JALR:  return C_JALR;
      OP_LUI:   return C_LUI;
      OP_AUIPC: return C_AUIPC;
      default:  return C_BAD;
    endcase
  endfunction

  // Idle control word for a given state: no strobes, selects 0, forced add.
  function automatic out_t base(logic [2:0] st);
    out_t o;
    o               = '0;
    o.state         = st;
    o.alu_force_add = 1'b1;
    o.illegal       = m_illegal;
    o.instret       = m_instret;
    return o;
  endfunction

  function automatic void push(out_t o, logic rdy, logic bt, logic [6:0] op);
    cycle_t c;
    c.rst = 1'b0; c.mem_ready = rdy; c.bt = bt; c.op = op; c.chk = 1'b1; c.exp = o;
    plan_q.push_back(c);
  endfunction

  // Reset cycles: the first shows the pre-reset state/counters, the rest the reset values.
  function automatic void plan_reset(logic [2:0] st, logic [IW-1:0] inst, logic ill, int n);
    cycle_t c;
    for (int i = 0; i < n; i++) begin
      c.rst = 1'b1; c.mem_ready = 1'b1; c.bt = 1'b1; c.op = OP_ADD; c.chk = 1'b1;
      c.exp = '0;
      c.exp.alu_force_add = 1'b1;
      if (i == 0) begin
        c.exp.state = st; c.exp.instret = inst; c.exp.illegal = ill;
      end
      plan_q.push_back(c);
    end
    m_instret = '0;
    m_illegal = 1'b0;
  endfunction

  // Expected cycle sequence of one instruction, from fetch through retirement.
  function automatic void plan_instr(logic [6:0] op, int fstall, int mstall, logic bt);
    cls_e k;
    out_t o;
    k = classify(op);
    for (int i = 0; i < fstall; i++) begin
      o = base(ST_FETCH); o.mem_req = 1'b1; push(o, 1'b0, bt, op);
    end
    o = base(ST_FETCH);
    o.mem_req = 1'b1; o.ir_we = 1'b1; o.oldpc_we = 1'b1; o.pc_we = 1'b1;
    push(o, 1'b1, bt, op);
    o = base(ST_DECODE); o.alu_a_sel = 2'd1; o.alu_b_sel = 2'd1; push(o, 1'b1, bt, op);
    if (k == C_BAD) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      m_illegal = 1'b1;
      for (int i = 0; i < 20; i++) begin
        o = base(ST_TRAP); push(o, 1'b1, bt, op);
      end
`else
      m_instret = m_instret + 1'b1;
`endif
      return;
    end
    o = base(ST_EXEC);
    case (k)
      C_R:     begin o.alu_a_sel = 2'd2; o.alu_b_sel = 2'd2; o.alu_force_add = 1'b0; end
      C_I:     begin o.alu_a_sel = 2'd2; o.alu_b_sel = 2'd1; o.alu_force_add = 1'b0; end
      C_L, C_S: begin o.alu_a_sel = 2'd2; o.alu_b_sel = 2'd1; end
      C_B:     begin o.pc_we = bt; o.pc_sel = 1'b1; end
      C_JAL:   begin o.pc_we = 1'b1; o.pc_sel = 1'b1; o.alu_a_sel = 2'd1; o.alu_b_sel = 2'd0; end
      C_JALR: begin
        o.alu_a_sel = 2'd2; o.alu_b_sel = 2'd1; o.pc_we = 1'b1;
        push(o, 1'b1, bt, op);
        o = base(ST_EXEC); o.alu_a_sel = 2'd1; o.alu_b_sel = 2'd0;
      end
      C_AUIPC: begin o.alu_a_sel = 2'd1; o.alu_b_sel = 2'd1; end
      default: ;
    endcase
    push(o, 1'b1, bt, op);
    if (k == C_B) begin
      m_instret = m_instret + 1'b1;
      return;
    end
    if (k == C_L || k == C_S) begin
      for (int i = 0; i <= mstall; i++) begin
        o = base(ST_MEM);
        o.mem_req = 1'b1; o.mem_addr_sel = 1'b1; o.mem_we = (k == C_S);
        push(o, (i == mstall), bt, op);
      end
      if (k == C_S) begin
        m_instret = m_instret + 1'b1;
        return;
      end
    end
    o = base(ST_WB);
    o.rf_we  = 1'b1;
    o.wb_sel = (k == C_L) ? 2'd1 : ((k == C_LUI) ? 2'd2 : 2'd0);
    push(o, 1'b1, bt, op);
    m_instret = m_instret + 1'b1;
  endfunction

  // Drive the first n planned cycles (all when n < 0), then drop the plan.
  task automatic run_plan(string tag, int n);
    int lim;
    cycle_t c;
    lim = (n < 0 || n > plan_q.size()) ? plan_q.size() : n;
    for (int i = 0; i < lim; i++) begin
      c = plan_q[i];
      rst = c.rst; mem_ready = c.mem_ready; branch_taken = c.bt; opcode = c.op;
      exp_cur = c.exp; chk_en = c.chk; cur_tag = $sformatf("%s[%0d]", tag, i);
      @(posedge clk);
      #1;
    end
    chk_en = 1'b0;
    plan_q.delete();
  endtask

  initial begin
    logic [IW-1:0] pre;
    rst = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; opcode = OP_ADD;
    m_instret = '0; m_illegal = 1'b0;
    @(posedge clk);
    #1;
    plan_reset(ST_FETCH, '0, 1'b0, 2);
    run_plan("reset", -1);

    plan_instr(OP_ADD, 2, 0, 1'b1);   run_plan("add", -1);
    check("instret_after_add", 64'(instret), 64'd1);

    plan_instr(OP_LW, 0, 3, 1'b1);
    check("lw_accept_to_fetch_cycles", 64'(plan_q.size()), 64'd8);
    run_plan("lw", -1);
    plan_instr(OP_SW, 1, 1, 1'b1);    run_plan("sw", -1);
    plan_instr(OP_BEQ, 0, 0, 1'b1);   run_plan("beq_taken", -1);
    plan_instr(OP_BEQ, 0, 0, 1'b0);   run_plan("beq_not_taken", -1);
    plan_instr(OP_JALR, 0, 0, 1'b1);  run_plan("jalr", -1);
    plan_instr(OP_JAL, 1, 0, 1'b0);   run_plan("jal", -1);
    plan_instr(OP_LUI, 0, 0, 1'b1);   run_plan("lui", -1);
    plan_instr(OP_AUIPC, 0, 0, 1'b1); run_plan("auipc", -1);
    plan_instr(OP_ADDI, 0, 0, 1'b1);  run_plan("addi", -1);
    check("instret_after_ten", 64'(instret), 64'd10);

    for (int i = 0; i < 8; i++) begin
      plan_instr((i % 2 == 0) ? OP_ADDI : OP_ADD, i % 3, 0, i[0]);
      run_plan("wrap_loop", -1);
    end
    check("instret_wrapped", 64'(instret), 64'd2);

    plan_instr(OP_BAD, 0, 0, 1'b1);   run_plan("illegal", -1);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("trap_illegal_flag", 64'(illegal), 64'd1);
    plan_reset(ST_TRAP, m_instret, 1'b1, 2);
    run_plan("trap_exit", -1);
    check("instret_after_trap_reset", 64'(instret), 64'd0);
`else
    check("instret_after_nop", 64'(instret), 64'd3);
`endif

    pre = m_instret;
    plan_instr(OP_LW, 1, 2, 1'b1);
    run_plan("lw_abandoned", 4);
    plan_reset(ST_MEM, pre, 1'b0, 2);
    run_plan("mid_reset", -1);
    plan_instr(OP_ADD, 0, 0, 1'b0);   run_plan("add_after_reset", -1);
    check("instret_after_mid_reset", 64'(instret), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
